// File: rtl/alu_seq_pkg.sv
// Shared constants for the ALU sequencer: opcodes, FSM encoding, instruction fields.
// Also provides the instruction decoder and the carry-flag selection helper.
package alu_seq_pkg;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_XOR = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_CLS = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_READ = 2'd1;
  localparam logic [1:0] ST_EXEC = 2'd2;
  localparam logic [1:0] ST_WB   = 2'd3;

  localparam int unsigned OP_LSB  = 6;
  localparam int unsigned RD_LSB  = 4;
  localparam int unsigned RS1_LSB = 2;
  localparam int unsigned RS2_LSB = 0;

  typedef struct packed {
    logic [1:0] op;
    logic [1:0] rd;
    logic [1:0] rs1;
    logic [1:0] rs2;
  } instr_t;

  function automatic instr_t decode_instr(input logic [7:0] raw);
    instr_t f;
    f.op  = raw[OP_LSB  +: 2];
    f.rd  = raw[RD_LSB  +: 2];
    f.rs1 = raw[RS1_LSB +: 2];
    f.rs2 = raw[RS2_LSB +: 2];
    return f;
  endfunction

  // Logic ops never carry; the rotate reports the bit that wrapped around.
  function automatic logic carry_flag(input logic [1:0] op, input logic co, input logic msb_a);
    logic c;
    case (op)
      OP_ADD:  c = co;
      OP_CLS:  c = msb_a;
      default: c = 1'b0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_seq_regfile.sv
// Four-entry register file: two combinational read ports, one synchronous write port.
// Synchronous active-high reset clears every entry.
module alu_seq_regfile #(
  parameter int unsigned DW = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic [1:0]    waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [1:0]    raddr_a_i,
  input  logic [1:0]    raddr_b_i,
  output logic [DW-1:0] rdata_a_o,
  output logic [DW-1:0] rdata_b_o
);

  logic [DW-1:0] mem_q [4];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 4; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = mem_q[raddr_a_i];
  assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle sequencer driving an external ALU: IDLE -> READ -> EXEC -> WB.
// Define ALU_SEQ_BYPASS_EN to register operands at acceptance and skip READ.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [7:0]    instr,
  input  logic          ld_en,
  input  logic [1:0]    ld_addr,
  input  logic [DW-1:0] ld_data,
  output logic [1:0]    ins_sel,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  input  logic [DW-1:0] alu_out,
  input  logic          alu_co,
  input  logic          alu_z,
  output logic          done,
  output logic [DW-1:0] result,
  output logic          flag_c,
  output logic          flag_z,
  output logic          busy
);

  logic [1:0]    state_q, state_d;
  instr_t        fld_q, fld_d;
  logic [DW-1:0] alu_a_q, alu_a_d;
  logic [DW-1:0] alu_b_q, alu_b_d;
  logic [1:0]    ins_sel_q, ins_sel_d;
  logic [DW-1:0] out_q, out_d;
  logic          co_q, co_d;
  logic          z_q, z_d;
  logic [DW-1:0] result_q, result_d;
  logic          flag_c_q, flag_c_d;
  logic          flag_z_q, flag_z_d;
  logic          done_q, done_d;

  instr_t        dec;
  logic          accept, ld_fire, wb_fire;
  logic          rf_we;
  logic [1:0]    rf_waddr, rf_raddr_a, rf_raddr_b;
  logic [DW-1:0] rf_wdata, rf_rdata_a, rf_rdata_b;
  logic [DW-1:0] opa, opb;

  assign dec         = decode_instr(instr);
  assign instr_ready = (state_q == ST_IDLE) && !rst;
  assign accept      = instr_valid && instr_ready;
  assign ld_fire     = ld_en && (state_q == ST_IDLE);
  assign wb_fire     = (state_q == ST_WB);

  // Loads only happen in IDLE and writeback only in WB, so the two never collide.
  assign rf_we    = ld_fire || wb_fire;
  assign rf_waddr = wb_fire ? fld_q.rd : ld_addr;
  assign rf_wdata = wb_fire ? out_q : ld_data;

`ifdef ALU_SEQ_BYPASS_EN
  assign rf_raddr_a = dec.rs1;
  assign rf_raddr_b = dec.rs2;
  // A load landing in the acceptance cycle is not yet in the file; forward it.
  assign opa = (ld_fire && (ld_addr == dec.rs1)) ? ld_data : rf_rdata_a;
  assign opb = (ld_fire && (ld_addr == dec.rs2)) ? ld_data : rf_rdata_b;
`else
  assign rf_raddr_a = fld_q.rs1;
  assign rf_raddr_b = fld_q.rs2;
  assign opa        = rf_rdata_a;
  assign opb        = rf_rdata_b;
`endif

  alu_seq_regfile #(
    .DW (DW)
  ) u_regfile (
    .clk_i     (clk),
    .rst_i     (rst),
    .we_i      (rf_we),
    .waddr_i   (rf_waddr),
    .wdata_i   (rf_wdata),
    .raddr_a_i (rf_raddr_a),
    .raddr_b_i (rf_raddr_b),
    .rdata_a_o (rf_rdata_a),
    .rdata_b_o (rf_rdata_b)
  );

  always_comb begin
    state_d   = state_q;
    fld_d     = fld_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    ins_sel_d = ins_sel_q;
    out_d     = out_q;
    co_d      = co_q;
    z_d       = z_q;
    result_d  = result_q;
    flag_c_d  = flag_c_q;
    flag_z_d  = flag_z_q;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          fld_d = dec;
`ifdef ALU_SEQ_BYPASS_EN
          alu_a_d   = opa;
          alu_b_d   = opb;
          ins_sel_d = dec.op;
          state_d   = ST_EXEC;
`else
          state_d   = ST_READ;
`endif
        end
      end
      ST_READ: begin
        alu_a_d   = opa;
        alu_b_d   = opb;
        ins_sel_d = fld_q.op;
        state_d   = ST_EXEC;
      end
      ST_EXEC: begin
        out_d   = alu_out;
        co_d    = carry_flag(ins_sel_q, alu_co, alu_a_q[DW-1]);
        z_d     = alu_z;
        state_d = ST_WB;
      end
      ST_WB: begin
        result_d = out_q;
        flag_c_d = co_q;
        flag_z_d = z_q;
        done_d   = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      fld_q     <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      ins_sel_q <= '0;
      out_q     <= '0;
      co_q      <= 1'b0;
      z_q       <= 1'b0;
      result_q  <= '0;
      flag_c_q  <= 1'b0;
      flag_z_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      fld_q     <= fld_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      ins_sel_q <= ins_sel_d;
      out_q     <= out_d;
      co_q      <= co_d;
      z_q       <= z_d;
      result_q  <= result_d;
      flag_c_q  <= flag_c_d;
      flag_z_q  <= flag_z_d;
      done_q    <= done_d;
    end
  end

  assign ins_sel = ins_sel_q;
  assign alu_a   = alu_a_q;
  assign alu_b   = alu_b_q;
  assign done    = done_q;
  assign result  = result_q;
  assign flag_c  = flag_c_q;
  assign flag_z  = flag_z_q;
  assign busy    = (state_q != ST_IDLE);

endmodule
